pll_ctrl: RTL

Sequencing controller that sits directly upstream of the Gowin PLL wrapper and drives its control pins. It holds the PLL in reset after power-up and applies the dynamic charge-pump and loop-filter settings. It waits for a stable lock before opening the output clock enables, and recovers from lock loss or lock timeout. It also accepts runtime loop-filter reconfiguration through a valid/ready handshake and reports lock status to the rest of the design.

---
 rtl/pll_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_ctrl.sv
// Sequencer for the Gowin PLL wrapper: holds the PLL in reset and applies loop settings.
// It gates the output clocks until lock is stable and recovers from lock loss or timeout.
module pll_ctrl #(
    parameter int         RESET_CYCLES        = 16,
    parameter int         LOCK_STABLE_CYCLES  = 256,
    parameter int         LOCK_TIMEOUT_CYCLES = 65536,
    parameter logic [5:0] ICP_DEFAULT         = 6'd16,
    parameter logic [2:0] LPFRES_DEFAULT      = 3'd2,
    parameter logic [1:0] LPFCAP_DEFAULT      = 2'd0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic [5:0] pll_icpsel_o,
    output logic [2:0] pll_lpfres_o,
    output logic [1:0] pll_lpfcap_o,
    output logic       pll_enclk0_o,
    output logic       pll_enclk2_o,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [5:0] cfg_icp_i,
    input  logic [2:0] cfg_lpfres_i,
    input  logic [1:0] cfg_lpfcap_i,
    output logic       locked_o,
    output logic       timeout_o,
    output logic [7:0] relock_cnt_o,
    output logic [1:0] dbg_state_o
);

    localparam int GATE_CYCLES = 2;
    localparam int RST_W  = $clog2(RESET_CYCLES + 1);
    localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ASSERT_RST = 2'd0,
        ST_WAIT_LOCK  = 2'd1,
        ST_RUN        = 2'd2,
        ST_GATE       = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic               pll_reset_q, pll_reset_d;
    logic               enclk0_q, enclk0_d;
    logic               enclk2_q, enclk2_d;
    logic               locked_q, locked_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         relock_q, relock_d;
    logic [5:0]         icp_q, icp_d;
    logic [2:0]         lpfres_q, lpfres_d;
    logic [1:0]         lpfcap_q, lpfcap_d;
    logic [5:0]         sh_icp_q, sh_icp_d;
    logic [2:0]         sh_lpfres_q, sh_lpfres_d;
    logic [1:0]         sh_lpfcap_q, sh_lpfcap_d;

    logic lock_sync;
    logic cfg_accept;

    assign lock_sync = sync2_q;

    // cfg handshake: a request is taken on a rising edge where cfg_valid_i and
    // cfg_ready_o are both high. Ready is offered only in RUN and drops on the
    // accepting edge, so one request is taken per RUN visit; hold cfg_* with valid.
    assign cfg_accept = cfg_valid_i && cfg_ready_q && (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        sync1_d     = pll_lock_i;
        sync2_d     = sync1_q;
        rst_cnt_d   = rst_cnt_q;
        stable_d    = stable_q;
        tmo_d       = tmo_q;
        gate_cnt_d  = gate_cnt_q;
        timeout_d   = 1'b0;
        relock_d    = relock_q;
        icp_d       = icp_q;
        lpfres_d    = lpfres_q;
        lpfcap_d    = lpfcap_q;
        sh_icp_d    = sh_icp_q;
        sh_lpfres_d = sh_lpfres_q;
        sh_lpfcap_d = sh_lpfcap_q;

        case (state_q)
            ST_ASSERT_RST: begin
                if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                tmo_d = tmo_q + TMO_W'(1);
                // The lock seen in the reset-release cycle predates the release, so it is not counted.
                if (!lock_sync) begin
                    stable_d = '0;
                end else if (tmo_q != '0) begin
                    stable_d = stable_q + STB_W'(1);
                end
                if (stable_q == STB_W'(LOCK_STABLE_CYCLES)) begin
                    state_d = ST_RUN;
                end else if (tmo_q == TMO_W'(LOCK_TIMEOUT_CYCLES)) begin
                    state_d   = ST_ASSERT_RST;
                    timeout_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_sync) begin
                    state_d = ST_GATE;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
                if (cfg_accept) begin
                    state_d     = ST_GATE;
                    sh_icp_d    = cfg_icp_i;
                    sh_lpfres_d = cfg_lpfres_i;
                    sh_lpfcap_d = cfg_lpfcap_i;
                end
            end
            ST_GATE: begin
                if (gate_cnt_q == GATE_W'(GATE_CYCLES - 1)) begin
                    state_d = ST_ASSERT_RST;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            default: state_d = ST_ASSERT_RST;
        endcase

        if (state_d != state_q) begin
            rst_cnt_d  = '0;
            stable_d   = '0;
            tmo_d      = '0;
            gate_cnt_d = '0;
        end

        // Loop settings only move while the PLL is being put back into reset.
        if (state_d == ST_ASSERT_RST && state_q != ST_ASSERT_RST) begin
            icp_d    = sh_icp_q;
            lpfres_d = sh_lpfres_q;
            lpfcap_d = sh_lpfcap_q;
        end

        pll_reset_d = (state_d == ST_ASSERT_RST);
        enclk0_d    = (state_d == ST_RUN);
        enclk2_d    = (state_d == ST_RUN);
        locked_d    = (state_d == ST_RUN);
        cfg_ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ASSERT_RST;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            rst_cnt_q   <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            gate_cnt_q  <= '0;
            pll_reset_q <= 1'b1;
            enclk0_q    <= 1'b0;
            enclk2_q    <= 1'b0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            timeout_q   <= 1'b0;
            relock_q    <= 8'd0;
            icp_q       <= ICP_DEFAULT;
            lpfres_q    <= LPFRES_DEFAULT;
            lpfcap_q    <= LPFCAP_DEFAULT;
            sh_icp_q    <= ICP_DEFAULT;
            sh_lpfres_q <= LPFRES_DEFAULT;
            sh_lpfcap_q <= LPFCAP_DEFAULT;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            rst_cnt_q   <= rst_cnt_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            gate_cnt_q  <= gate_cnt_d;
            pll_reset_q <= pll_reset_d;
            enclk0_q    <= enclk0_d;
            enclk2_q    <= enclk2_d;
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
            timeout_q   <= timeout_d;
            relock_q    <= relock_d;
            icp_q       <= icp_d;
            lpfres_q    <= lpfres_d;
            lpfcap_q    <= lpfcap_d;
            sh_icp_q    <= sh_icp_d;
            sh_lpfres_q <= sh_lpfres_d;
            sh_lpfcap_q <= sh_lpfcap_d;
        end
    end

    assign pll_reset_o  = pll_reset_q;
    assign pll_icpsel_o = icp_q;
    assign pll_lpfres_o = lpfres_q;
    assign pll_lpfcap_o = lpfcap_q;
    assign pll_enclk0_o = enclk0_q;
    assign pll_enclk2_o = enclk2_q;
    assign cfg_ready_o  = cfg_ready_q;
    assign locked_o     = locked_q;
    assign timeout_o    = timeout_q;
    assign relock_cnt_o = relock_q;
    assign dbg_state_o  = state_q;

endmodule
